// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 panel-side responder: opcode masks,
// DDRAM geometry, FSM states and address-counter helpers.
package lcd_pkg;

  localparam int LINE_LEN   = 40;
  localparam int DDRAM_SIZE = 80;

  localparam logic [7:0] LINE0_BASE = 8'h00;
  localparam logic [7:0] LINE1_BASE = 8'h40;
  localparam logic [7:0] SPACE      = 8'h20;

  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FILL = 2'd2,
    ST_BUSY = 2'd3
  } lcd_state_t;

  function automatic logic [6:0] ddram_index(input logic [6:0] addr);
    return addr[6] ? (7'(LINE_LEN) + {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
  endfunction

  function automatic logic addr_valid(input logic [6:0] addr);
    return addr[5:0] < 6'(LINE_LEN);
  endfunction

  // Each line ends at base+39 and wraps into the other line, not into the gap.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] last0;
    logic [6:0] last1;
    last0 = LINE0_BASE[6:0] + 7'(LINE_LEN - 1);
    last1 = LINE1_BASE[6:0] + 7'(LINE_LEN - 1);
    if (inc) begin
      if (ac == last1)      return LINE0_BASE[6:0];
      else if (ac == last0) return LINE1_BASE[6:0];
      else                  return ac + 7'd1;
    end else begin
      if (ac == LINE0_BASE[6:0])      return last1;
      else if (ac == LINE1_BASE[6:0]) return last0;
      else                            return ac - 7'd1;
    end
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: one write port, registered bus and debug read ports.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [6:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [6:0] i_bus_raddr,
  output logic [7:0] o_bus_rdata,
  input  logic [6:0] i_dbg_raddr,
  output logic [7:0] o_dbg_rdata
);

  logic [7:0] r_mem [DDRAM_SIZE];
  logic [7:0] r_bus_rdata;
  logic [7:0] r_dbg_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr < 7'(DDRAM_SIZE))) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the output registers are reset; array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bus_rdata <= 8'h00;
      r_dbg_rdata <= 8'h00;
    end else begin
      r_bus_rdata <= (i_bus_raddr < 7'(DDRAM_SIZE)) ? r_mem[i_bus_raddr] : 8'h00;
      r_dbg_rdata <= (i_dbg_raddr < 7'(DDRAM_SIZE)) ? r_mem[i_dbg_raddr] : 8'h00;
    end
  end

  assign o_bus_rdata = r_bus_rdata;
  assign o_dbg_rdata = r_dbg_rdata;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Panel-side HD44780 8-bit bus model: synchronises the bus, decodes commands,
// holds DDRAM/AC/flags and emulates the busy flag including the clear fill.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 76500
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_db_i,
  output logic [7:0] lcd_db_o,
  output logic       lcd_db_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_id,
  output logic       entry_s,
  output logic       proto_err,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [10:0] r_sync1, r_sync2;
  logic        r_e_d;
  lcd_state_t  r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [6:0]  r_fill_idx, w_fill_next;
  logic        r_cmd_rs, w_cmd_rs_next;
  logic [7:0]  r_cmd_db, w_cmd_db_next;
  logic [6:0]  r_ac, w_ac_next;
  logic        r_disp, w_disp_next, r_cursor, w_cursor_next, r_blink, w_blink_next;
  logic        r_id, w_id_next, r_s, w_s_next, r_cg, w_cg_next;
  logic        r_perr, w_perr_next, r_oe, w_oe_next;
  logic        w_e_s, w_rs_s, w_rw_s, w_e_rise, w_e_fall, w_long;
  logic [7:0]  w_db_s, w_bus_rdata;
  logic        w_we;
  logic [6:0]  w_waddr;
  logic [7:0]  w_wdata;

  assign w_e_s    = r_sync2[10];
  assign w_rs_s   = r_sync2[9];
  assign w_rw_s   = r_sync2[8];
  assign w_db_s   = r_sync2[7:0];
  assign w_e_rise = w_e_s & ~r_e_d;
  assign w_e_fall = ~w_e_s & r_e_d;
  assign w_long   = (w_db_s[7:2] == 6'd0) && (w_db_s[1:0] != 2'd0);

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    w_fill_next   = r_fill_idx;
    w_cmd_rs_next = r_cmd_rs;
    w_cmd_db_next = r_cmd_db;
    w_ac_next     = r_ac;
    w_disp_next   = r_disp;
    w_cursor_next = r_cursor;
    w_blink_next  = r_blink;
    w_id_next     = r_id;
    w_s_next      = r_s;
    w_cg_next     = r_cg;
    w_perr_next   = r_perr;
    w_oe_next     = r_oe;
    w_we          = 1'b0;
    w_waddr       = ddram_index(r_ac);
    w_wdata       = r_cmd_db;

    if (w_e_rise && w_rw_s) w_oe_next = 1'b1;
    if (w_e_fall)           w_oe_next = 1'b0;

    if (w_e_fall) begin
      if (w_rw_s) begin
        if (w_rs_s) w_ac_next = ac_step(r_ac, r_id);
      end else if (r_state != ST_IDLE || (w_rs_s && r_cg)) begin
        w_perr_next = 1'b1;
      end else begin
        w_state_next  = ST_EXEC;
        w_cmd_rs_next = w_rs_s;
        w_cmd_db_next = w_db_s;
        w_cnt_next    = (!w_rs_s && w_long) ? CNT_W'(CLEAR_CYCLES) : CNT_W'(BUSY_CYCLES);
      end
    end

    case (r_state)
      ST_EXEC: begin
        w_state_next = ST_BUSY;
        if (r_cmd_rs) begin
          w_we      = 1'b1;
          w_ac_next = ac_step(r_ac, r_id);
        end else begin
          w_cg_next = 1'b0;
          if ((r_cmd_db & OP_SET_DDRAM) != 8'h00) begin
            if (addr_valid(r_cmd_db[6:0])) w_ac_next = r_cmd_db[6:0];
            else                           w_perr_next = 1'b1;
          end else if ((r_cmd_db & OP_SET_CGRAM) != 8'h00) begin
            w_cg_next = 1'b1;
          end else if ((r_cmd_db & OP_FUNC_SET) != 8'h00) begin
            if (!r_cmd_db[4]) w_perr_next = 1'b1;
          end else if ((r_cmd_db & OP_SHIFT) != 8'h00) begin
            if (!r_cmd_db[3]) w_ac_next = ac_step(r_ac, r_cmd_db[2]);
          end else if ((r_cmd_db & OP_DISP_CTRL) != 8'h00) begin
            {w_disp_next, w_cursor_next, w_blink_next} = r_cmd_db[2:0];
          end else if ((r_cmd_db & OP_ENTRY) != 8'h00) begin
            {w_id_next, w_s_next} = r_cmd_db[1:0];
          end else if ((r_cmd_db & OP_HOME) != 8'h00) begin
            w_ac_next = LINE0_BASE[6:0];
          end else if ((r_cmd_db & OP_CLEAR) != 8'h00) begin
            w_state_next = ST_FILL;
            w_fill_next  = 7'd0;
          end
        end
      end
      ST_FILL: begin
        w_we    = 1'b1;
        w_waddr = r_fill_idx;
        w_wdata = SPACE;
        if (r_fill_idx == 7'(DDRAM_SIZE - 1)) begin
          w_state_next = ST_BUSY;
          w_ac_next    = LINE0_BASE[6:0];
          w_id_next    = 1'b1;
        end else begin
          w_fill_next = r_fill_idx + 7'd1;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) w_state_next = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_e_d      <= 1'b0;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_fill_idx <= 7'd0;
      r_cmd_rs   <= 1'b0;
      r_cmd_db   <= 8'h00;
      r_ac       <= 7'd0;
      r_disp     <= 1'b0;
      r_cursor   <= 1'b0;
      r_blink    <= 1'b0;
      r_id       <= 1'b1;
      r_s        <= 1'b0;
      r_cg       <= 1'b0;
      r_perr     <= 1'b0;
      r_oe       <= 1'b0;
    end else begin
      r_sync1    <= {lcd_e, lcd_rs, lcd_rw, lcd_db_i};
      r_sync2    <= r_sync1;
      r_e_d      <= w_e_s;
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_fill_idx <= w_fill_next;
      r_cmd_rs   <= w_cmd_rs_next;
      r_cmd_db   <= w_cmd_db_next;
      r_ac       <= w_ac_next;
      r_disp     <= w_disp_next;
      r_cursor   <= w_cursor_next;
      r_blink    <= w_blink_next;
      r_id       <= w_id_next;
      r_s        <= w_s_next;
      r_cg       <= w_cg_next;
      r_perr     <= w_perr_next;
      r_oe       <= w_oe_next;
    end
  end

  // Write enable is gated by reset so a reset mid-fill stops the fill on that edge.
  lcd_ddram u_ddram (
    .i_clk       (CLOCK_50),
    .i_rst_n     (KEY0),
    .i_we        (w_we & KEY0),
    .i_waddr     (w_waddr),
    .i_wdata     (w_wdata),
    .i_bus_raddr (ddram_index(r_ac)),
    .o_bus_rdata (w_bus_rdata),
    .i_dbg_raddr (ddram_index(dbg_addr)),
    .o_dbg_rdata (dbg_data)
  );

  assign busy      = (r_state != ST_IDLE);
  assign lcd_db_oe = r_oe;
  assign lcd_db_o  = r_oe ? (w_rs_s ? w_bus_rdata : {busy, r_ac}) : 8'h00;
  assign ac        = r_ac;
  assign disp_on   = r_disp;
  assign cursor_on = r_cursor;
  assign blink_on  = r_blink;
  assign entry_id  = r_id;
  assign entry_s   = r_s;
  assign proto_err = r_perr;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed + randomized bench for lcd_hd44780_responder against a linear-index
// behavioural model of the display RAM and address counter.
module tb_lcd_hd44780_responder;

  localparam int BUSY_CYC  = 60;
  localparam int CLEAR_CYC = 100;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0 = 1'b0;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [7:0] lcd_db_i = 8'h00;
  logic [6:0] dbg_addr = 7'd0;
  logic [7:0] lcd_db_o, dbg_data;
  logic       lcd_db_oe, busy, disp_on, cursor_on, blink_on, entry_id, entry_s, proto_err;
  logic [6:0] ac;

  lcd_hd44780_responder #(.BUSY_CYCLES(BUSY_CYC), .CLEAR_CYCLES(CLEAR_CYC)) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_db_i(lcd_db_i), .lcd_db_o(lcd_db_o), .lcd_db_oe(lcd_db_oe), .busy(busy), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .entry_id(entry_id),
    .entry_s(entry_s), .proto_err(proto_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: AC held as a linear cell index 0..79 (line 1 starts at cell 40).
  logic [7:0] m_mem [80];
  int   m_idx = 0;
  logic m_id = 1'b1, m_s = 1'b0, m_disp = 1'b0, m_cur = 1'b0, m_blk = 1'b0;
  logic m_cg = 1'b0, m_perr = 1'b0;

  function automatic logic [6:0] to_ac(input int idx);
    return (idx < 40) ? 7'(idx) : 7'(idx + 24);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_id = 1'b1; m_s = 1'b0; m_disp = 1'b0; m_cur = 1'b0; m_blk = 1'b0;
    m_cg = 1'b0; m_perr = 1'b0;
  endtask

  task automatic model_write(input logic rs, input logic [7:0] db);
    int hb;
    int a;
    if (rs) begin
      if (m_cg) m_perr = 1'b1;
      else begin
        m_mem[m_idx] = db;
        m_idx = m_id ? (m_idx + 1) % 80 : (m_idx + 79) % 80;
      end
    end else begin
      hb = -1;
      for (int b = 0; b < 8; b++) if (db[b]) hb = b;
      a = int'(db[6:0]);
      case (hb)
        7: if (a < 40) m_idx = a;
           else if (a >= 64 && a < 104) m_idx = a - 24;
           else m_perr = 1'b1;
        6: m_cg = 1'b1;
        5: if (!db[4]) m_perr = 1'b1;
        4: if (!db[3]) m_idx = db[2] ? (m_idx + 1) % 80 : (m_idx + 79) % 80;
        3: {m_disp, m_cur, m_blk} = db[2:0];
        2: {m_id, m_s} = db[1:0];
        1: m_idx = 0;
        0: begin
          for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
          m_idx = 0;
          m_id  = 1'b1;
        end
        default: ;
      endcase
      if (hb >= 0 && hb != 6) m_cg = 1'b0;
    end
  endtask

  task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] db,
                           output logic [7:0] rd, output logic oe);
    @(negedge CLOCK_50);
    lcd_rs = rs; lcd_rw = rw; lcd_db_i = db;
    @(negedge CLOCK_50);
    lcd_e = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    rd = lcd_db_o;
    oe = lcd_db_oe;
    lcd_e = 1'b0;
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy !== 1'b0 && n < 4000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("ready_timeout", 32'(busy), 32'(0));
  endtask

  task automatic send(input logic rs, input logic [7:0] db);
    logic [7:0] rd;
    logic oe;
    model_write(rs, db);
    bus_cycle(rs, 1'b0, db, rd, oe);
    chk("oe_on_write", 32'(oe), 32'(0));
    wait_ready();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_ac"},     32'(ac),        32'(to_ac(m_idx)));
    chk({tag, "_disp"},   32'(disp_on),   32'(m_disp));
    chk({tag, "_cursor"}, 32'(cursor_on), 32'(m_cur));
    chk({tag, "_blink"},  32'(blink_on),  32'(m_blk));
    chk({tag, "_id"},     32'(entry_id),  32'(m_id));
    chk({tag, "_s"},      32'(entry_s),   32'(m_s));
    chk({tag, "_perr"},   32'(proto_err), 32'(m_perr));
    chk({tag, "_busy"},   32'(busy),      32'(0));
  endtask

  task automatic dbg_check_all(input string tag);
    for (int i = 0; i < 80; i++) begin
      @(negedge CLOCK_50);
      dbg_addr = to_ac(i);
      @(negedge CLOCK_50);
      chk({tag, "_ram"}, 32'(dbg_data), 32'(m_mem[i]));
    end
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic oe;
    logic rl;
    logic [6:0] ac_before;

    for (int i = 0; i < 80; i++) m_mem[i] = 8'h00;

    repeat (3) @(negedge CLOCK_50);
    chk("rst_db_o", 32'(lcd_db_o), 32'(0));
    chk("rst_oe", 32'(lcd_db_oe), 32'(0));
    chk("rst_dbg", 32'(dbg_data), 32'(0));
    check_regs("rst");
    KEY0 = 1'b1;

    send(0, 8'h38); send(0, 8'h38); send(0, 8'h0F); send(0, 8'h01); send(0, 8'h06);
    check_regs("init");
    chk("init_ac0", 32'(ac), 32'(0));
    dbg_check_all("init");

    send(1, 8'h31); send(1, 8'h32); send(1, 8'h33);
    send(0, 8'hC0);
    send(1, 8'h41); send(1, 8'h42); send(1, 8'h43);
    chk("data_ac43", 32'(ac), 32'h43);
    check_regs("data");
    dbg_check_all("data");

    send(0, 8'h81);
    bus_cycle(1, 1, 8'h00, rd, oe);
    m_idx = (m_idx + 1) % 80;
    chk("dread_oe", 32'(oe), 32'(1));
    chk("dread_data", 32'(rd), 32'h32);
    chk("dread_ac", 32'(ac), 32'h02);
    chk("dread_nobusy", 32'(busy), 32'(0));

    send(0, 8'hA7); send(1, 8'h58);
    chk("wrap_inc_ac", 32'(ac), 32'h40);
    send(0, 8'h04); send(0, 8'h80); send(1, 8'h59);
    chk("wrap_dec_ac", 32'(ac), 32'h67);
    send(0, 8'h06);
    check_regs("wrap");

    send(0, 8'h80);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rl = 1'($urandom_range(0, 1));
        send(0, {5'b00010, rl, 2'b00});
      end
      send(1, 8'($urandom_range(0, 255)));
    end
    check_regs("rand");
    dbg_check_all("rand");

    model_write(1, 8'h41);
    bus_cycle(1, 0, 8'h41, rd, oe);
    bus_cycle(0, 1, 8'h00, rd, oe);
    chk("stat_oe", 32'(oe), 32'(1));
    chk("stat_data", 32'(rd), 32'({1'b1, to_ac(m_idx)}));
    bus_cycle(1, 0, 8'h5A, rd, oe);
    m_perr = 1'b1;
    wait_ready();
    check_regs("busywr");
    dbg_check_all("busywr");

    @(negedge CLOCK_50);
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_db_i = 8'h01;
    @(negedge CLOCK_50);
    lcd_e = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    lcd_e = 1'b0;
    repeat (34) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("clr_busy", 32'(busy), 32'(1));
    KEY0 = 1'b0;
    for (int i = 0; i < 30; i++) m_mem[i] = 8'h20;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    KEY0 = 1'b1;
    chk("clr_rst_busy", 32'(busy), 32'(0));
    chk("clr_rst_ac", 32'(ac), 32'(0));
    send(0, 8'h38); send(0, 8'h38); send(0, 8'h0F); send(0, 8'h06);
    check_regs("clr");
    dbg_check_all("clr");

    ac_before = ac;
    send(0, 8'hB0);
    chk("badaddr_ac", 32'(ac), 32'(ac_before));
    chk("badaddr_perr", 32'(proto_err), 32'(1));
    check_regs("badaddr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
